// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads instruction RAM from a byte stream (count, LE words, XOR checksum)
// and holds the core in reset until a checksum-verified load completes.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [N-1:0]  wr_data,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int BPW = N / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;

  state_t        state, state_next;
  logic [AW:0]   words_left;
  logic [BW-1:0] byte_idx;
  logic [7:0]    xsum;
  logic [N-9:0]  shreg;
  logic [N-1:0]  word_next;
  logic          take, last_byte, count_bad, next_busy;

  assign byte_ready = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign take       = byte_valid && byte_ready;
  assign last_byte  = (byte_idx == BW'(BPW - 1));
  assign count_bad  = int'(byte_data) > (1 << AW);
  // Earlier bytes sit in the low positions, so the newest byte lands on top.
  assign word_next  = {byte_data, shreg};
  assign next_busy  = (state_next == COUNT) || (state_next == DATA) || (state_next == CHECK);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = COUNT;
      COUNT:           if (take) state_next = count_bad ? ERR : DATA;
      DATA:            if (take && last_byte && words_left == (AW+1)'(1)) state_next = CHECK;
      CHECK:           if (take) state_next = (byte_data == xsum) ? DONE : ERR;
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_left <= '0;
      byte_idx   <= '0;
      xsum       <= '0;
      shreg      <= '0;
    end else begin
      wr_en     <= 1'b0;
      busy      <= next_busy;
      done      <= (state_next == DONE);
      err       <= (state_next == ERR);
      cpu_reset <= (state_next != DONE);
      // Address advances the edge after the write strobe; a full load wraps back to 0.
      if (wr_en) wr_addr <= wr_addr + 1'b1;
      case (state)
        COUNT: if (take) begin
          words_left <= (byte_data == 8'd0) ? DEPTH : (AW+1)'(byte_data);
          byte_idx   <= '0;
          wr_addr    <= '0;
          xsum       <= byte_data;
        end
        DATA: if (take) begin
          xsum  <= xsum ^ byte_data;
          shreg <= word_next[N-1:8];
          if (last_byte) begin
            byte_idx   <= '0;
            wr_en      <= 1'b1;
            wr_data    <= word_next;
            words_left <= words_left - 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader: table-driven loads plus
// hand-written corner sequences, with a write scoreboard.
module tb_imem_loader;
  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, wr_en, cpu_reset, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [AW+N-1:0] exp_q[$];
  logic [N-1:0] words[64];
  int cyc = 0;
  int last_wr = -1;
  bit spacing_on = 1'b0;

  typedef struct {
    logic [7:0] c;
    int         nw;
    int         gap;
    bit         flip;
    bit         exp_done;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [AW+N-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e[AW+N-1:N]));
        check("wr_data", 64'(wr_data), 64'(e[N-1:0]));
      end
      if (spacing_on && last_wr >= 0) check("wr_spacing", 64'(cyc - last_wr), 64'd4);
      last_wr = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      n = $urandom_range(gap, 0);
      repeat (n) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        tick();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (!byte_ready) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
    tick();
  endtask

  task automatic run_load(input logic [7:0] c, input int nw, input int ck, input bit flip,
                          input int gap, input bit mid_start, input bit exp_done);
    logic [7:0] xs, b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("ready_after_start", 64'(byte_ready), 64'd1);
    check("cpu_reset_after_start", 64'(cpu_reset), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    check("err_cleared", 64'(err), 64'd0);
    send_byte(c, gap);
    xs = c;
    for (int w = 0; w < nw; w++) begin
      if (mid_start && w == 1) begin
        byte_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_ignores_start", 64'(busy), 64'd1);
      end
      for (int i = 0; i < N/8; i++) begin
        b = words[w][8*i +: 8];
        if (i == N/8 - 1) exp_q.push_back({AW'(w), words[w]});
        send_byte(b, gap);
        xs ^= b;
      end
    end
    if (ck >= 0) xs = 8'(ck);
    if (flip) xs ^= 8'h01;
    send_byte(xs, gap);
    byte_valid = 1'b0;
    check("done", 64'(done), 64'(exp_done));
    check("err", 64'(err), 64'(!exp_done));
    check("busy_end", 64'(busy), 64'd0);
    check("cpu_reset_end", 64'(cpu_reset), 64'(!exp_done));
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{c: 8'd1,  nw: 1,  gap: 0, flip: 1'b0, exp_done: 1'b1};
    vecs[1] = '{c: 8'd5,  nw: 5,  gap: 2, flip: 1'b1, exp_done: 1'b0};
    vecs[2] = '{c: 8'd64, nw: 64, gap: 0, flip: 1'b0, exp_done: 1'b1};
    vecs[3] = '{c: 8'd2,  nw: 2,  gap: 4, flip: 1'b0, exp_done: 1'b1};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    tick(); tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // Good 3-word load with the documented stream, then the same with a bad checksum.
    words[0] = 32'h91003c0a; words[1] = 32'haa14018b; words[2] = 32'h8a14018c;
    run_load(8'h03, 3, 8'h83, 1'b0, 0, 1'b0, 1'b1);
    check("good_wr_addr_end", 64'(wr_addr), 64'd3);
    run_load(8'h03, 3, 8'h82, 1'b0, 0, 1'b0, 1'b0);

    // Illegal count: straight to ERR, nothing written.
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'h41, 0);
    byte_valid = 1'b0;
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_done", 64'(done), 64'd0);
    check("illegal_ready", 64'(byte_ready), 64'd0);
    check("illegal_busy", 64'(busy), 64'd0);
    check("illegal_cpu_reset", 64'(cpu_reset), 64'd1);
    repeat (3) tick();

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      run_load(vecs[v].c, vecs[v].nw, -1, vecs[v].flip, vecs[v].gap, 1'b0, vecs[v].exp_done);
    end

    // Full 64-word load at one byte per cycle: writes every 4 cycles, address wraps.
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    spacing_on = 1'b1; last_wr = -1;
    run_load(8'h00, 64, -1, 1'b0, 0, 1'b0, 1'b1);
    spacing_on = 1'b0;
    check("full_wr_addr_wrap", 64'(wr_addr), 64'd0);

    // Gapped load with a start pulse in the middle of DATA.
    run_load(8'd10, 10, -1, 1'b0, 3, 1'b1, 1'b1);

    // Reset (with start) on the edge that would accept a word's final byte.
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'd3, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({AW'(0), words[0]});
      send_byte(words[0][8*i +: 8], 0);
    end
    for (int i = 0; i < 3; i++) send_byte(words[1][8*i +: 8], 0);
    byte_valid = 1'b1; byte_data = words[1][31:24];
    reset = 1'b1; start = 1'b1;
    tick();
    byte_valid = 1'b0;
    check_reset_values("midreset");
    reset = 1'b0; start = 1'b0;
    tick();
    check("post_reset_idle_busy", 64'(busy), 64'd0);
    check("post_reset_idle_ready", 64'(byte_ready), 64'd0);
    check("post_reset_q", 64'(exp_q.size()), 64'd0);
    run_load(8'd3, 3, -1, 1'b0, 0, 1'b0, 1'b1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
